v_query_resp_q: RTL

Response queue directly downstream of the list-query pipeline. The query pipe has no backpressure: its registered response (valid, key, size, error, listsize) arrives exactly one cycle after issue. This block captures each response into a small FIFO and presents it to the host over a valid/ready handshake. It exports a credit signal that upstream issue logic must honour, so that responses are never dropped.

---
 rtl/v_query_resp_q.sv | 93 +++++++++
 1 files changed

// File: rtl/v_query_resp_q.sv
// Response queue behind the list-query pipe: captures each 1-cycle-latency response into a FIFO,
// hands it to the host via valid/ready and exports issue credit. Optional: V_QUERY_RESP_BYPASS_EN.
package v_pkg;
  localparam int unsigned KEY_BITS    = 16;
  localparam int unsigned VOLUME_BITS = 16;
  typedef logic [7:0] listsize_t;
endpackage

module v_query_resp_q #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_init_r,
  input  logic                         i_iss_vld,
  output logic                         o_iss_rdy,
  input  logic                         i_lut_vld_r,
  input  logic [v_pkg::KEY_BITS-1:0]   i_lut_key,
  input  logic [v_pkg::VOLUME_BITS-1:0] i_lut_size,
  input  logic                         i_lut_error,
  input  v_pkg::listsize_t             i_lut_listsize,
  output logic                         o_rsp_vld,
  input  logic                         i_rsp_rdy,
  output logic [v_pkg::KEY_BITS-1:0]   o_rsp_key,
  output logic [v_pkg::VOLUME_BITS-1:0] o_rsp_size,
  output logic                         o_rsp_error,
  output v_pkg::listsize_t             o_rsp_listsize,
  output logic [CNT_W-1:0]             o_occ_r,
  output logic                         o_ovf_r
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LS_W  = $bits(v_pkg::listsize_t);
  localparam int unsigned DW    = 1 + LS_W + v_pkg::VOLUME_BITS + v_pkg::KEY_BITS;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   CRED_LIM = (CNT_W + 1)'(DEPTH);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             inflight_r;

  logic [DW-1:0]    lut_ent, head_ent, rsp_ent;
  logic [CNT_W:0]   cred_sum;
  logic             empty, full, byp, iss_acc, pop_st, push_ok, ovf_set;

  assign lut_ent  = {i_lut_error, i_lut_listsize, i_lut_size, i_lut_key};
  assign head_ent = mem[rd_ptr];
  assign empty    = (o_occ_r == '0);
  assign full     = (o_occ_r == FULL_CNT);

  // Credit comes from flops only; a same-cycle pop frees credit one cycle later.
  assign cred_sum  = {1'b0, o_occ_r} + {{CNT_W{1'b0}}, inflight_r};
  assign o_iss_rdy = (cred_sum < CRED_LIM);
  assign iss_acc   = i_iss_vld & o_iss_rdy & ~i_init_r;

`ifdef V_QUERY_RESP_BYPASS_EN
  assign byp     = empty & i_lut_vld_r;
  assign rsp_ent = byp ? lut_ent : head_ent;
`else
  assign byp     = 1'b0;
  assign rsp_ent = head_ent;
`endif

  assign o_rsp_vld = ~empty | byp;
  assign {o_rsp_error, o_rsp_listsize, o_rsp_size, o_rsp_key} = rsp_ent;

  // pop_st is a pop out of storage; a bypassed response that is taken is never written.
  assign pop_st  = ~empty & i_rsp_rdy;
  assign push_ok = i_lut_vld_r & (~full | pop_st) & ~(byp & i_rsp_rdy);
  assign ovf_set = i_lut_vld_r & full & ~pop_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_occ_r    <= '0;
      inflight_r <= 1'b0;
      o_ovf_r    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      inflight_r <= iss_acc;
      if (push_ok) begin
        mem[wr_ptr] <= lut_ent;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_st) rd_ptr <= rd_ptr + 1'b1;
      o_occ_r <= o_occ_r + CNT_W'(push_ok) - CNT_W'(pop_st);
      if (ovf_set) o_ovf_r <= 1'b1;
    end
  end

endmodule
